// File: rtl/exc_responder_pkg.sv
// Shared definitions for the storage-exception responder: FSM state encoding,
// cause codes, vector offsets, MSR bit indices (big-endian numbering) and helpers.
package exc_responder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StSave,
        StRedir,
        StWait,
        StRfi
    } exc_state_e;

    // Encoded in priority order, oldest instruction first
    typedef enum logic [1:0] {
        CauseDsi = 2'd0,
        CauseSc  = 2'd1,
        CauseIsi = 2'd2,
        CauseExt = 2'd3
    } exc_cause_e;

    localparam logic [31:0] VEC_OFF_DSI = 32'h0000_0300;
    localparam logic [31:0] VEC_OFF_ISI = 32'h0000_0400;
    localparam logic [31:0] VEC_OFF_EXT = 32'h0000_0500;
    localparam logic [31:0] VEC_OFF_SC  = 32'h0000_0C00;

    // MSR bit indices in architectural (bit 0 = MSB) numbering
    localparam int unsigned MSR_EE = 16;
    localparam int unsigned MSR_PR = 17;
    localparam int unsigned MSR_IR = 26;
    localparam int unsigned MSR_DR = 27;

    localparam logic [31:0] DSISR_DSI   = 32'h0800_0000;
    localparam logic [31:0] DSISR_STORE = 32'h0200_0000;

    function automatic logic [31:0] vec_offset(input exc_cause_e cause);
        logic [31:0] off;
        off = VEC_OFF_EXT;
        unique case (cause)
            CauseDsi: off = VEC_OFF_DSI;
            CauseSc:  off = VEC_OFF_SC;
            CauseIsi: off = VEC_OFF_ISI;
            CauseExt: off = VEC_OFF_EXT;
        endcase
        return off;
    endfunction

    // Internal MSR storage is [31:0]; convert an architectural index to a vector position
    function automatic int unsigned msr_pos(input int unsigned idx);
        return 31 - idx;
    endfunction

    // On exception entry EE, PR, IR and DR are cleared, every other bit is kept
    function automatic logic [31:0] msr_on_entry(input logic [31:0] msr);
        logic [31:0] r;
        r = msr;
        r[msr_pos(MSR_EE)] = 1'b0;
        r[msr_pos(MSR_PR)] = 1'b0;
        r[msr_pos(MSR_IR)] = 1'b0;
        r[msr_pos(MSR_DR)] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder for exception causes: dsi > sc_req > isi > ext.
module exc_prio_enc
    import exc_responder_pkg::*;
(
    input  logic       dsi,
    input  logic       sc_req,
    input  logic       isi,
    input  logic       ext,
    output logic       valid,
    output exc_cause_e cause
);

    // Pick the highest-priority pending cause
    always_comb begin
        valid = dsi | sc_req | isi | ext;
        cause = CauseExt;
        if (dsi) begin
            cause = CauseDsi;
        end else if (sc_req) begin
            cause = CauseSc;
        end else if (isi) begin
            cause = CauseIsi;
        end
    end

endmodule

// File: rtl/exc_responder.sv
// Exception responder: services dsi/isi/syscall/external-interrupt requests and rfi,
// owning MSR, SRR0, SRR1 (and DAR/DSISR when EXC_DAR_EN is defined).
// Optional feature macro: EXC_DAR_EN (capture DAR/DSISR on DSI entry).
module exc_responder
    import exc_responder_pkg::*;
#(
    parameter logic [31:0] VEC_BASE = 32'h0000_0000,
    parameter logic [31:0] RST_MSR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dsi,
    input  logic        isi,
    input  logic        sc_req,
    input  logic        ext_int,
    input  logic        rfi_req,
    input  logic [31:0] mem_pc,
    input  logic [31:0] if_pc,
    input  logic [31:0] sc_pc,
    input  logic [31:0] ext_pc,
    input  logic [31:0] dsi_addr,
    input  logic        dsi_store,
    input  logic        mtmsr_we,
    input  logic [31:0] mtmsr_data,
    output logic        dsi_ack,
    output logic        isi_ack,
    output logic        sc_ack,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [0:31] MSR,
    output logic [31:0] SRR0,
    output logic [31:0] SRR1,
    output logic [31:0] DAR,
    output logic [31:0] DSISR
);

    exc_state_e  state_q, state_d;
    exc_cause_e  cause_q;
    exc_cause_e  req_cause;
    logic        req_valid;
    logic [31:0] msr_q;
    logic [31:0] srr0_q, srr1_q;
    logic [31:0] save_pc;
    logic        in_idle;

    assign in_idle = (state_q == StIdle);

    exc_prio_enc u_prio (
        .dsi    (dsi),
        .sc_req (sc_req),
        .isi    (isi),
        .ext    (ext_int & msr_q[msr_pos(MSR_EE)]),
        .valid  (req_valid),
        .cause  (req_cause)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: exceptions beat rfi in IDLE, entry sequence is fixed length
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StFlush;
                end else if (rfi_req) begin
                    state_d = StRfi;
                end
            end
            StFlush: state_d = StSave;
            StSave:  state_d = StRedir;
            StRedir: state_d = StWait;
            StWait:  state_d = StIdle;
            StRfi:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        flush       = (state_q == StFlush) || (state_q == StRfi);
        redirect    = (state_q == StRedir) || (state_q == StRfi);
        busy        = !in_idle;
        redirect_pc = 32'h0;
        if (state_q == StRedir) begin
            redirect_pc = VEC_BASE + vec_offset(cause_q);
        end else if (state_q == StRfi) begin
            redirect_pc = srr0_q;
        end
        dsi_ack = (state_q == StRedir) && (cause_q == CauseDsi);
        isi_ack = (state_q == StRedir) && (cause_q == CauseIsi);
        sc_ack  = (state_q == StRedir) && (cause_q == CauseSc);
    end

    // Cause is frozen in IDLE so a request dropping mid-entry still completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= CauseDsi;
        end else if (in_idle && req_valid) begin
            cause_q <= req_cause;
        end
    end

    // Return address saved for each cause; syscall resumes after the sc instruction
    always_comb begin
        save_pc = ext_pc;
        unique case (cause_q)
            CauseDsi: save_pc = mem_pc;
            CauseSc:  save_pc = sc_pc + 32'd4;
            CauseIsi: save_pc = if_pc;
            CauseExt: save_pc = ext_pc;
        endcase
    end

    // MSR: entry masking, rfi restore, mtmsr only when IDLE is otherwise quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msr_q <= RST_MSR;
        end else if (state_q == StSave) begin
            msr_q <= msr_on_entry(msr_q);
        end else if (state_q == StRfi) begin
            msr_q <= srr1_q;
        end else if (in_idle && !req_valid && !rfi_req && mtmsr_we) begin
            msr_q <= mtmsr_data;
        end
    end

    // SRR0/SRR1 capture on the SAVE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srr0_q <= 32'h0;
            srr1_q <= 32'h0;
        end else if (state_q == StSave) begin
            srr0_q <= save_pc;
            srr1_q <= msr_q;
        end
    end

    assign MSR  = msr_q;
    assign SRR0 = srr0_q;
    assign SRR1 = srr1_q;

`ifdef EXC_DAR_EN
    logic [31:0] dar_q, dsisr_q;

    // Fault address/status captured only on DSI entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dar_q   <= 32'h0;
            dsisr_q <= 32'h0;
        end else if (state_q == StSave && cause_q == CauseDsi) begin
            dar_q   <= dsi_addr;
            dsisr_q <= DSISR_DSI | (dsi_store ? DSISR_STORE : 32'h0);
        end
    end

    assign DAR   = dar_q;
    assign DSISR = dsisr_q;
`else
    logic unused_dar;

    assign unused_dar = ^{dsi_addr, dsi_store};
    assign DAR        = 32'h0;
    assign DSISR      = 32'h0;
`endif

endmodule
